// File: rtl/board_pkg.sv
// Shared constants, state encoding and cell addressing for the board renderer.
package board_pkg;
    localparam int COLS  = 10;
    localparam int ROWS  = 20;
    localparam int CW    = 3;
    localparam int CELLS = ROWS * COLS;
    localparam int IDX_W = 8;
    localparam int ROW_W = 5;
    localparam int COL_W = 4;
    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_COPY    = 2'd2
    } state_e;

    typedef enum logic [CW-1:0] {
        CLR_EMPTY  = 3'd0,
        CLR_CYAN   = 3'd1,
        CLR_YELLOW = 3'd2,
        CLR_PURPLE = 3'd3,
        CLR_GREEN  = 3'd4,
        CLR_RED    = 3'd5,
        CLR_BLUE   = 3'd6,
        CLR_ORANGE = 3'd7
    } color_e;

    function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
        return IDX_W'(row) * IDX_W'(COLS) + IDX_W'(col);
    endfunction
endpackage

// File: rtl/board_bank.sv
// One board's worth of cell colours: single write port, pixel and copy read ports.
module board_bank
    import board_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [CW-1:0]    wdata_i,
    input  logic [IDX_W-1:0] pix_addr_i,
    output logic [CW-1:0]    pix_data_o,
    input  logic [IDX_W-1:0] copy_addr_i,
    output logic [CW-1:0]    copy_data_o
);
    logic [CW-1:0] cells_q [CELLS];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++) cells_q[i] <= '0;
        end else if (we_i) begin
            cells_q[waddr_i] <= wdata_i;
        end
    end

    assign pix_data_o  = (pix_addr_i  < IDX_W'(CELLS)) ? cells_q[pix_addr_i]  : '0;
    assign copy_data_o = (copy_addr_i < IDX_W'(CELLS)) ? cells_q[copy_addr_i] : '0;
endmodule

// File: rtl/board_renderer.sv
// Double-buffered game board: back bank is written by game logic, swapped at the
// frame boundary, and the front bank is scanned out as a registered pixel colour.
//   state   | meaning
//   IDLE    | accepting cell writes and commits into the back bank
//   PENDING | commit taken, waiting for the first blanking line to swap
//   COPY    | seeding the new back bank from the freshly displayed front bank
module board_renderer
    import board_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] count_x,
    input  logic [CNT_W-1:0] count_y,
    input  logic             in_display,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  logic [CW-1:0]    wr_color,
    input  logic             commit_valid,
    output logic             commit_ready,
    output logic             busy,
    output logic             swap_pulse,
    output logic [CW-1:0]    rgb,
    output logic             hsync,
    output logic             vsync
);
    state_e           state_q, state_d;
    logic             bank_sel_q, bank_sel_d;
    logic [IDX_W-1:0] copy_idx_q, copy_idx_d;
    logic [CW-1:0]    rgb_q;
    logic             hsync_q, vsync_q;

    logic             pix_in, frame_edge, wr_in_range;
    logic [IDX_W-1:0] pix_idx;
    logic             back_we;
    logic [IDX_W-1:0] back_waddr;
    logic [CW-1:0]    back_wdata;
    logic [CW-1:0]    pix0, pix1, copy0, copy1, front_pix, front_copy;

    assign pix_in      = in_display && (count_x < CNT_W'(COLS)) && (count_y < CNT_W'(ROWS));
    assign pix_idx     = pix_in ? cell_idx(count_y[ROW_W-1:0], count_x[COL_W-1:0]) : '0;
    assign frame_edge  = (count_y == CNT_W'(ROWS)) && (count_x == '0);
    assign wr_in_range = (wr_row < ROW_W'(ROWS)) && (wr_col < COL_W'(COLS));
    assign front_pix   = bank_sel_q ? pix1  : pix0;
    assign front_copy  = bank_sel_q ? copy1 : copy0;

    // bank_sel selects the front bank; the other one is always the write target
    board_bank u_bank0 (
        .clock       (clock),
        .reset_n     (reset_n),
        .we_i        (back_we & bank_sel_q),
        .waddr_i     (back_waddr),
        .wdata_i     (back_wdata),
        .pix_addr_i  (pix_idx),
        .pix_data_o  (pix0),
        .copy_addr_i (copy_idx_q),
        .copy_data_o (copy0)
    );

    board_bank u_bank1 (
        .clock       (clock),
        .reset_n     (reset_n),
        .we_i        (back_we & ~bank_sel_q),
        .waddr_i     (back_waddr),
        .wdata_i     (back_wdata),
        .pix_addr_i  (pix_idx),
        .pix_data_o  (pix1),
        .copy_addr_i (copy_idx_q),
        .copy_data_o (copy1)
    );

    always_comb begin
        state_d      = state_q;
        bank_sel_d   = bank_sel_q;
        copy_idx_d   = copy_idx_q;
        wr_ready     = 1'b0;
        commit_ready = 1'b0;
        busy         = 1'b0;
        swap_pulse   = 1'b0;
        back_we      = 1'b0;
        back_waddr   = copy_idx_q;
        back_wdata   = front_copy;
        if (reset_n) begin
            case (state_q)
                ST_IDLE: begin
                    wr_ready     = 1'b1;
                    commit_ready = 1'b1;
                    if (wr_valid && wr_in_range) begin
                        back_we    = 1'b1;
                        back_waddr = cell_idx(wr_row, wr_col);
                        back_wdata = wr_color;
                    end
                    if (commit_valid) state_d = ST_PENDING;
                end
                ST_PENDING: begin
                    busy = 1'b1;
                    if (frame_edge) begin
                        bank_sel_d = ~bank_sel_q;
                        swap_pulse = 1'b1;
                        copy_idx_d = '0;
                        state_d    = ST_COPY;
                    end
                end
                ST_COPY: begin
                    busy       = 1'b1;
                    back_we    = 1'b1;
                    copy_idx_d = copy_idx_q + IDX_W'(1);
                    if (copy_idx_q == IDX_W'(CELLS - 1)) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bank_sel_q <= 1'b0;
            copy_idx_q <= '0;
            rgb_q      <= '0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            copy_idx_q <= copy_idx_d;
            rgb_q      <= pix_in ? front_pix : '0;
            hsync_q    <= hsync_in;
            vsync_q    <= vsync_in;
        end
    end

    assign rgb   = rgb_q;
    assign hsync = hsync_q;
    assign vsync = vsync_q;
endmodule

// File: doc/board_renderer.md
Name: board_renderer

Overview:
- Downstream consumer of the VGA sync/counter stage.
- Holds the ROWS x COLS game board as two cell-colour banks (front/back).
- Game logic writes cells into the back bank over a valid/ready port and requests a commit; the swap happens only at the frame boundary, so no tearing.
- Each cycle, the front-bank cell addressed by count_x/count_y is turned into a registered colour, with sync signals realigned to it.

Parameters:
- COLS, 10, board width in cells; equals the horizontal display pixel count.
- ROWS, 20, board height in cells; equals the vertical display line count.
- CW, 3, colour bits per cell (0 = empty/black).

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- count_x  in  10  horizontal pixel counter from sync stage
- count_y  in  10  vertical line counter from sync stage
- in_display  in  1  high when the current pixel is in the display area
- hsync_in  in  1  hsync from sync stage
- vsync_in  in  1  vsync from sync stage
- wr_valid  in  1  cell write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_row  in  5  target row, 0..ROWS-1
- wr_col  in  4  target column, 0..COLS-1
- wr_color  in  CW  colour to write
- commit_valid  in  1  request to publish the back bank
- commit_ready  out  1  commit accepted when commit_valid & commit_ready
- busy  out  1  high in PENDING or COPY
- swap_pulse  out  1  one-cycle pulse on the cycle the bank swap occurs
- rgb  out  CW  pixel colour
- hsync  out  1  hsync_in delayed 1 cycle
- vsync  out  1  vsync_in delayed 1 cycle

Behaviour:
- Clock and reset:
  - One clock domain.
  - Reset is synchronous and active-low: on a clock edge with reset_n=0, both banks are cleared to 0, bank_sel=0 (bank0 is front), state=IDLE.
  - Reset values: rgb=0, hsync=1, vsync=1, swap_pulse=0, busy=0, wr_ready=0, commit_ready=0.
  - Reset asserted mid-PENDING or mid-COPY aborts the operation; nothing persists.
- Cell index: idx = row*COLS + col, 8 bits, range 0..199.
- Pixel path:
  - Latency 1 cycle.
  - rgb <= (in_display && count_x<COLS && count_y<ROWS) ? front[count_y*COLS+count_x] : 0.
  - hsync and vsync are delayed by the same single register stage, so they stay aligned with rgb.
- Frame boundary: the cycle where count_y==ROWS and count_x==0 (first blanking line).
- FSM states: IDLE, PENDING, COPY.
- IDLE:
  - wr_ready=1, commit_ready=1.
  - An accepted write stores wr_color into the back bank at idx.
  - A write with wr_row>=ROWS or wr_col>=COLS is accepted and dropped.
  - An accepted commit moves to PENDING.
  - Write and commit in the same cycle: both are accepted, and the write is included in the commit.
- PENDING:
  - wr_ready=0, commit_ready=0, busy=1.
  - On the frame boundary: toggle bank_sel, pulse swap_pulse, clear copy_idx, go to COPY.
  - A commit accepted on the boundary cycle itself waits for the next frame.
  - The new front bank is used from the next cycle on.
- COPY:
  - busy=1; both ready outputs stay 0.
  - Each cycle: back[copy_idx] <= front[copy_idx], then copy_idx++.
  - After idx ROWS*COLS-1 has been copied, go to IDLE. COPY lasts exactly 200 cycles.
  - This makes the back bank start from the displayed board.
  - The display keeps reading the front bank in parallel; the copy never writes the front bank.
- commit_valid held high in IDLE with no writes: a commit is still accepted (re-publishes an identical board).
- Counter values outside the display (count_x>=COLS or count_y>=ROWS) never index memory.

Decomposition:
- Shared package (board_pkg):
  - COLS, ROWS, CW constants.
  - Cell index width (8).
  - State encoding for IDLE/PENDING/COPY.
  - Colour codes (EMPTY=0 plus 7 piece colours).
- Sub-module board_bank: one ROWS*COLS x CW register array with one write port and two combinational read ports (pixel and copy).
- board_renderer instantiates two board_bank instances, muxed by bank_sel.

Test Plan:
- Reset then a full frame with no writes: rgb=0 for every pixel; hsync/vsync equal the inputs delayed 1 cycle; busy=0; wr_ready=1.
- Write (row 3, col 4, colour 5), commit, run to count_y=20/count_x=0:
  - swap_pulse for exactly 1 cycle.
  - Next frame: rgb=5 one cycle after count_x=4/count_y=3 with in_display=1; every other pixel 0.
- After a swap: busy high for exactly 200 cycles, wr_ready=0 throughout. Then write (0,0)=2 and commit: the next frame shows both (3,4)=5 and (0,0)=2, which proves the copy.
- Write (row 25, col 4)=7 and (row 2, col 12)=7 with a commit: both writes accepted, and no pixel ever shows 7.
- Write and commit in the same cycle on the frame-boundary cycle: the swap waits a full frame (~450 cycles), and the write is visible after it.
- Assert reset_n=0 during COPY at copy_idx=100: banks cleared, state IDLE, rgb=0 next frame, busy=0 from the next cycle.
